// File: rtl/sat_mul_seq.sv
// sat_mul_seq: sequential signed multiplier / multiply-accumulate with
// symmetric saturation to [-SAT, +SAT].
// Operation order: take the operand magnitudes, run WIDTH shift-add steps,
// restore the sign, add the optional addend, clamp, then hold the result
// until the consumer takes it.
// Optional feature: define SAT_MUL_OVF_FLAG_EN to add the ovf output, which
// is high when the held result was clamped.
module sat_mul_seq #(
  parameter int WIDTH = 11,
  parameter int SAT   = 999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] addend,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SAT_MUL_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] out
);

  localparam int PW = 2 * WIDTH;        // unsigned product width
  localparam int SW = PW + 1;           // signed sum width, no wrap possible
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic signed [SW-1:0] SAT_HI = SW'(SAT);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SATR,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;   // multiplicand magnitude, shifts left
  logic [WIDTH-1:0]  mplier_q, mplier_d; // multiplier magnitude, shifts right
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  addend_q, addend_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              ovf_q, ovf_d;

  logic signed [SW-1:0] prod_s;
  logic signed [SW-1:0] addend_s;
  logic signed [SW-1:0] sum_s;

  // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps
  // to 2^(WIDTH-1), which still fits, so negation never overflows.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // Signed product plus optional addend, formed wide enough that it cannot wrap.
  assign prod_s   = sign_q ? -$signed({1'b0, prod_q}) : $signed({1'b0, prod_q});
  assign addend_s = $signed({{(SW-WIDTH){addend_q[WIDTH-1]}}, addend_q});
  assign sum_s    = prod_s + (mode_q ? addend_s : '0);

  // Next-state and datapath update for each phase of the operation.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    addend_d = addend_q;
    out_d    = out_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_f(acc)};
          mplier_d = mag_f(arg1);
          prod_d   = '0;
          cnt_d    = '0;
          sign_d   = acc[WIDTH-1] ^ arg1[WIDTH-1];
          mode_d   = mode;
          addend_d = addend;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SATR;
        end
      end
      SATR: begin
        if (sum_s > SAT_HI) begin
          out_d = SAT_HI[WIDTH-1:0];
          ovf_d = 1'b1;
        end else if (sum_s < SAT_LO) begin
          out_d = SAT_LO[WIDTH-1:0];
          ovf_d = 1'b1;
        end else begin
          out_d = sum_s[WIDTH-1:0];
          ovf_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too, so out reads 0 after reset.
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mode_q   <= 1'b0;
      addend_q <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      addend_q <= addend_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

`ifdef SAT_MUL_OVF_FLAG_EN
  assign ovf = ovf_q;
`else
  // The clamp flag is only observable through ovf; without it the register
  // has no reader and is removed by synthesis.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sat_mul_seq.sv
// Scoreboard bench for sat_mul_seq: the driver pushes hand-computed results
// at accept time, and a negedge monitor pops and compares on each output
// transfer. It also checks latency, output stability under backpressure,
// and abort on reset.
module tb_sat_mul_seq;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] acc = '0;
  logic [W-1:0] arg1 = '0;
  logic [W-1:0] addend = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
`ifdef SAT_MUL_OVF_FLAG_EN
  logic         ovf;
`endif

  sat_mul_seq #(.WIDTH(W), .SAT(999)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .acc       (acc),
    .arg1      (arg1),
    .addend    (addend),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SAT_MUL_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         ovf;
    int           acc_cyc;
    string        name;
  } exp_t;

  typedef struct {
    bit    m;
    int    a;
    int    b;
    int    ad;
    int    eo;
    bit    eovf;
    string name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  bit   seen_valid = 1'b0;
  int   xfer_cyc = -100;
  int   last_accept = -100;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got out_valid=1 out=%0d expected no result", $signed(out));
      end else begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check({sb[0].name, "_latency"}, 32'(cyc + 1 - sb[0].acc_cyc), 32'(W + 2));
        end
        check({sb[0].name, "_out"}, 32'($signed(out)), 32'($signed(sb[0].out)));
`ifdef SAT_MUL_OVF_FLAG_EN
        check({sb[0].name, "_ovf"}, 32'(ovf), 32'(sb[0].ovf));
`endif
        check({sb[0].name, "_in_ready_low"}, 32'(in_ready), 32'(0));
        if (out_ready) begin
          xfer_cyc = cyc + 1;
          void'(sb.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit m, input int a, input int b, input int ad);
    @(posedge clk);
    #1;
    mode     = m;
    acc      = W'(a);
    arg1     = W'(b);
    addend   = W'(ad);
    in_valid = 1'b1;
  endtask

  // Wait for the accepting edge; optionally record the expected result.
  task automatic wait_accept(input string name, input int eo, input bit eovf, input bit push);
    bit   got = 1'b0;
    exp_t e;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: got no accept expected accept within 60 cycles", name);
    end else begin
      last_accept = cyc + 1;
      if (push) begin
        e.out     = W'(eo);
        e.ovf     = eovf;
        e.acc_cyc = cyc + 1;
        e.name    = name;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    // Scramble operands while the operation is in flight.
    in_valid = 1'b0;
    mode     = 1'($urandom);
    acc      = W'($urandom);
    arg1     = W'($urandom);
    addend   = W'($urandom);
  endtask

  task automatic issue(input vec_t v);
    drive(v.m, v.a, v.b, v.ad);
    wait_accept(v.name, v.eo, v.eovf, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    vecs.push_back('{1'b0,    20,   -30,     0,  -600, 1'b0, "mul_neg"});
    vecs.push_back('{1'b0,    40,    30,     0,   999, 1'b1, "mul_sat_pos"});
    vecs.push_back('{1'b0,   -40,    30,     0,  -999, 1'b1, "mul_sat_neg"});
    vecs.push_back('{1'b1,    30,    30,   100,   999, 1'b1, "mac_sat_pos"});
    vecs.push_back('{1'b1,    30,    30,  -200,   700, 1'b0, "mac_sub"});
    vecs.push_back('{1'b0, -1024, -1024,     0,   999, 1'b1, "mul_minneg_sq"});
    vecs.push_back('{1'b0, -1024,     0,     0,     0, 1'b0, "mul_minneg_zero"});
    vecs.push_back('{1'b1,     0,     5, -1024,  -999, 1'b1, "mac_addend_sat"});
    vecs.push_back('{1'b0,    31,    32,     0,   992, 1'b0, "mul_near_sat"});
    vecs.push_back('{1'b1,    -7,     9,     3,   -60, 1'b0, "mac_neg"});
    vecs.push_back('{1'b0,  1023,    -1,     0,  -999, 1'b1, "mul_max_neg1"});
    vecs.push_back('{1'b0,     3,     4,   500,    12, 1'b0, "mul_ignore_addend"});
    vecs.push_back('{1'b1,   -33,    30,     0,  -990, 1'b0, "mac_zero_addend"});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out", 32'($signed(out)), 32'(0));
`ifdef SAT_MUL_OVF_FLAG_EN
    check("reset_ovf", 32'(ovf), 32'(0));
`endif

    // Directed vectors.
    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Backpressure: result held for 5 stalled cycles, next op waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue('{1'b0, 20, -30, 0, -600, 1'b0, "stall"});
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    check("stall_out_valid_seen", 32'(out_valid), 32'(1));
    drive(1'b0, 5, 6, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_out_valid", 32'(out_valid), 32'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept("after_stall", 30, 1'b0, 1'b1);
    check("accept_after_xfer", 32'(last_accept), 32'(xfer_cyc + 1));
    drain();

    // Reset mid-CALC aborts the in-flight operation.
    drive(1'b0, 40, 30, 0);
    wait_accept("aborted", 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_out", 32'($signed(out)), 32'(0));
    repeat (20) @(negedge clk);
    check("abort_no_result_out", 32'($signed(out)), 32'(0));

    // Recovery after abort.
    issue('{1'b1, -2, 3, 10, 4, 1'b0, "post_abort"});
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
